// File: rtl/spi_transfer_controller.sv
// -----------------------------------------------------------------------------
// spi_transfer_controller
//   Master-side SPI byte sequencer. It accepts a one-cycle send_data request
//   from the register block and divides PCLK to make SCLK. It drives SS low for
//   the transfer, shifts DW bits out on MOSI while capturing DW bits from MISO,
//   then returns the received byte with a one-cycle receive_data strobe.
//
// Ports:
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   mstr, spe, spi_mode  enables; a start is accepted only in run mode (00)
//   cpol, cpha, lsbfe    frame format, latched at start
//   sppr, spr            baud select; divisor (sppr+1) << (spr+1), latched
//   send_data, mosi_data start request and byte to send
//   miso                 serial input
//   sclk, mosi, ss       SPI pins (ss active low)
//   tip                  transfer in progress
//   receive_data         one-cycle strobe, miso_data valid
//   miso_data            last received byte
// -----------------------------------------------------------------------------
module spi_transfer_controller #(
   parameter int DW    = 8,
   parameter int CNT_W = 12
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          mstr,
   input  logic          spe,
   input  logic          cpol,
   input  logic          cpha,
   input  logic          lsbfe,
   input  logic [1:0]    spi_mode,
   input  logic [2:0]    sppr,
   input  logic [2:0]    spr,
   input  logic          send_data,
   input  logic [DW-1:0] mosi_data,
   input  logic          miso,
   output logic          sclk,
   output logic          mosi,
   output logic          ss,
   output logic          tip,
   output logic          receive_data,
   output logic [DW-1:0] miso_data
);

   localparam int EW = $clog2(2*DW+1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt, r_half_m1;
   logic [EW-1:0]    r_edge_cnt;
   logic [DW-1:0]    r_tx, r_rx;
   logic             r_cpha, r_lsbfe;

   logic             w_enabled, w_abort, w_start;
   logic [CNT_W-1:0] w_pre, w_half, w_half_m1;
   logic             w_tick, w_last, w_odd, w_sample, w_drive;
   logic [EW-1:0]    w_edge_nxt;

   function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] v, input logic lsb);
      return lsb ? {1'b0, v[DW-1:1]} : {v[DW-2:0], 1'b0};
   endfunction

   assign w_enabled = mstr & spe & (spi_mode == 2'b00);
   // Wait mode (01) lets the current byte finish; only stop mode or losing
   // spe/mstr cuts it short.
   assign w_abort   = ~mstr | ~spe | (spi_mode == 2'b10);
   assign w_start   = (r_state == IDLE) & send_data & w_enabled;

   // Half period H = (sppr+1) << spr; the counter runs H-1 .. 0.
   assign w_pre     = CNT_W'(sppr) + CNT_W'(1);
   assign w_half    = w_pre << spr;
   assign w_half_m1 = w_half - CNT_W'(1);

   assign w_tick     = (r_state == SHIFT) & (r_cnt == '0);
   assign w_edge_nxt = r_edge_cnt + EW'(1);
   assign w_last     = (w_edge_nxt == EW'(2*DW));
   assign w_odd      = w_edge_nxt[0];
   // CPHA=0: the first bit is already on MOSI at start, so sample on odd
   // edges and advance on even ones (not after the final edge).
   // CPHA=1: advance on odd edges (the first re-drives bit 0), sample on even.
   assign w_sample   = w_tick & (r_cpha ? ~w_odd : w_odd);
   assign w_drive    = w_tick & (r_cpha ? w_odd : (~w_odd & ~w_last));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_start) w_next = SHIFT;
         SHIFT:   if (w_abort) w_next = IDLE;
                  else if (w_tick && w_last) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         sclk         <= 1'b0;
         mosi         <= 1'b0;
         ss           <= 1'b1;
         tip          <= 1'b0;
         receive_data <= 1'b0;
         miso_data    <= '0;
         r_cnt        <= '0;
         r_half_m1    <= '0;
         r_edge_cnt   <= '0;
         r_tx         <= '0;
         r_rx         <= '0;
         r_cpha       <= 1'b0;
         r_lsbfe      <= 1'b0;
      end else begin
         receive_data <= 1'b0;
         case (r_state)
            IDLE: begin
               ss   <= 1'b1;
               tip  <= 1'b0;
               sclk <= cpol;
               if (w_start) begin
                  ss         <= 1'b0;
                  tip        <= 1'b1;
                  r_cpha     <= cpha;
                  r_lsbfe    <= lsbfe;
                  r_half_m1  <= w_half_m1;
                  r_cnt      <= w_half_m1;
                  r_edge_cnt <= '0;
                  r_rx       <= '0;
                  mosi       <= lsbfe ? mosi_data[0] : mosi_data[DW-1];
                  // CPHA=1 re-drives bit 0 on the first edge, so keep it.
                  r_tx       <= cpha ? mosi_data : shift_out(mosi_data, lsbfe);
               end
            end
            SHIFT: begin
               if (w_abort) begin
                  ss   <= 1'b1;
                  tip  <= 1'b0;
                  sclk <= cpol;
               end else if (w_tick) begin
                  sclk       <= ~sclk;
                  r_cnt      <= r_half_m1;
                  r_edge_cnt <= w_edge_nxt;
                  if (w_sample)
                     r_rx <= r_lsbfe ? {miso, r_rx[DW-1:1]} : {r_rx[DW-2:0], miso};
                  if (w_drive) begin
                     mosi <= r_lsbfe ? r_tx[0] : r_tx[DW-1];
                     r_tx <= shift_out(r_tx, r_lsbfe);
                  end
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            DONE: begin
               miso_data    <= r_rx;
               receive_data <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_transfer_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_transfer_controller
//   Directed bench for spi_transfer_controller. A behavioural SPI slave returns
//   a chosen byte on MISO and captures MOSI. Each accepted start pushes its
//   hand-computed result (rx byte, tx byte, strobe cycle, first SCLK edge cycle)
//   onto a scoreboard queue, and a monitor checks it when receive_data fires.
// -----------------------------------------------------------------------------
module tb_spi_transfer_controller;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       mstr = 1'b1, spe = 1'b1, cpol = 1'b0, cpha = 1'b0, lsbfe = 1'b0;
   logic [1:0] spi_mode = 2'b00;
   logic [2:0] sppr = 3'd0, spr = 3'd0;
   logic       send_data = 1'b0;
   logic [7:0] mosi_data = 8'h00;
   logic       miso;
   logic       sclk, mosi, ss, tip, receive_data;
   logic [7:0] miso_data;

   spi_transfer_controller #(.DW(8), .CNT_W(12)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .mstr(mstr), .spe(spe), .cpol(cpol),
      .cpha(cpha), .lsbfe(lsbfe), .spi_mode(spi_mode), .sppr(sppr), .spr(spr),
      .send_data(send_data), .mosi_data(mosi_data), .miso(miso), .sclk(sclk),
      .mosi(mosi), .ss(ss), .tip(tip), .receive_data(receive_data),
      .miso_data(miso_data)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int ncmp = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] rx;
      logic [7:0] tx;
      int         rd_cyc;
      int         fe_cyc;
   } exp_t;
   exp_t sb[$];

   // Slave configuration, set by the stimulus process only.
   logic       s_cpha = 1'b0, s_lsb = 1'b0;
   logic [7:0] s_byte = 8'h00;

   // Slave state, owned by the slave process only.
   int         s_edges, s_tx_i, s_rx_i, s_fe;
   logic [7:0] s_cap;
   logic       s_prev_ss, s_prev_sclk;

   function automatic logic sbit(input logic [7:0] b, input logic lsb, input int i);
      return lsb ? b[i] : b[7-i];
   endfunction

   always @(negedge PCLK) begin
      if (!PRESETn) begin
         miso = 1'b0; s_prev_ss = 1'b1; s_prev_sclk = sclk;
         s_edges = 0; s_tx_i = 0; s_rx_i = 0; s_cap = 8'h00; s_fe = 0;
      end else begin
         if (s_prev_ss && !ss) begin
            s_edges = 0; s_tx_i = 0; s_rx_i = 0; s_cap = 8'h00;
            if (!s_cpha) begin
               miso = sbit(s_byte, s_lsb, 0);
               s_tx_i = 1;
            end
         end else if (!ss && sclk !== s_prev_sclk) begin
            s_edges++;
            if (s_edges == 1) s_fe = cyc;
            if (((s_edges % 2) == 1) == !s_cpha) begin
               if (s_rx_i < 8) s_cap[s_lsb ? s_rx_i : 7 - s_rx_i] = mosi;
               s_rx_i++;
            end
            if (s_cpha ? (s_edges % 2 == 1) : (s_edges % 2 == 0 && s_edges != 16)) begin
               if (s_tx_i < 8) miso = sbit(s_byte, s_lsb, s_tx_i);
               s_tx_i++;
            end
         end
         s_prev_ss = ss;
         s_prev_sclk = sclk;
      end
   end

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge PCLK) begin
      if (PRESETn && receive_data === 1'b1) begin
         if (sb.size() == 0) begin
            ncmp++; nerr++;
            $display("FAIL unexpected_strobe: receive_data at cycle %0d with nothing expected", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("miso_data", miso_data, e.rx);
            chk("tx_byte",   s_cap,     e.tx);
            chk("rd_cycle",  cyc,       e.rd_cyc);
            chk("fe_cycle",  s_fe,      e.fe_cyc);
         end
      end
   end

   int t0 = 0;

   task automatic start(input logic c_pol, input logic c_pha, input logic lsb,
                        input logic [2:0] pp, input logic [2:0] rr,
                        input logic [7:0] tx, input logic [7:0] rx, input bit expect_it);
      int h;
      exp_t e;
      @(negedge PCLK);
      cpol = c_pol; cpha = c_pha; lsbfe = lsb; sppr = pp; spr = rr;
      s_cpha = c_pha; s_lsb = lsb; s_byte = rx;
      repeat (2) @(negedge PCLK);
      mosi_data = tx; send_data = 1'b1; t0 = cyc;
      h = (int'(pp) + 1) << rr;
      if (expect_it) begin
         e.rx = rx; e.tx = tx; e.rd_cyc = t0 + 2 + 16*h; e.fe_cyc = t0 + 1 + h;
         sb.push_back(e);
      end
      @(negedge PCLK);
      send_data = 1'b0;
   endtask

   task automatic wait_done(input int maxc);
      for (int i = 0; i < maxc; i++) begin
         @(negedge PCLK);
         if (sb.size() == 0 && tip === 1'b0) return;
      end
      ncmp++; nerr++;
      $display("FAIL timeout: transfer not finished after %0d cycles, pending %0d", maxc, sb.size());
   endtask

   initial begin
      int ss_low;
      bit hit;
      // Reset values.
      repeat (3) @(negedge PCLK);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_ss", ss, 1);
      chk("rst_tip", tip, 0);
      chk("rst_rd", receive_data, 0);
      chk("rst_miso_data", miso_data, 8'h00);
      PRESETn = 1'b1;
      repeat (2) @(negedge PCLK);

      // Mode 0, H=1, MSB first.
      start(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hA5, 8'h3C, 1'b1);
      chk("m0_ss_c1", ss, 0);
      chk("m0_tip_c1", tip, 1);
      chk("m0_mosi_first", mosi, 1);
      wait_done(100);
      chk("m0_ss_idle", ss, 1);

      // Mode 3, H=4, LSB first.
      start(1'b1, 1'b1, 1'b1, 3'd1, 3'd1, 8'h81, 8'h5A, 1'b1);
      chk("m3_sclk_idle", sclk, 1);
      wait_done(200);
      chk("m3_sclk_end", sclk, 1);

      // Maximum divisor, H=1024.
      start(1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'h96, 8'h69, 1'b1);
      wait_done(20000);

      // send_data and new mosi_data mid-transfer must be ignored.
      start(1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 8'h5B, 8'hC3, 1'b1);
      repeat (4) @(negedge PCLK);
      send_data = 1'b1; mosi_data = 8'hFF;
      @(negedge PCLK);
      send_data = 1'b0;
      wait_done(200);
      repeat (40) @(negedge PCLK);

      // spe dropped after the 6th SCLK edge: abort, no strobe.
      start(1'b1, 1'b0, 1'b0, 3'd0, 3'd1, 8'h77, 8'h11, 1'b0);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge PCLK); #1;
         if (s_edges >= 6) begin hit = 1'b1; break; end
      end
      chk("abort_reached_edge6", hit, 1);
      spe = 1'b0;
      @(negedge PCLK);
      chk("abort_ss", ss, 1);
      chk("abort_tip", tip, 0);
      chk("abort_sclk", sclk, 1);
      chk("abort_miso_data", miso_data, 8'hC3);
      repeat (60) @(negedge PCLK);
      chk("abort_miso_data_hold", miso_data, 8'hC3);
      spe = 1'b1;

      // Wait mode mid-transfer: byte completes, next start refused.
      start(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h3C, 8'hA5, 1'b1);
      repeat (4) @(negedge PCLK);
      spi_mode = 2'b01;
      wait_done(100);
      @(negedge PCLK);
      mosi_data = 8'h42; send_data = 1'b1;
      @(negedge PCLK);
      send_data = 1'b0;
      ss_low = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge PCLK);
         if (ss !== 1'b1) ss_low++;
      end
      chk("wait_ss_low_cycles", ss_low, 0);
      spi_mode = 2'b00;
      repeat (5) @(negedge PCLK);

      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
